// File: rtl/spell_mem_arbiter.sv
// Two-port (host/core) arbiter onto a single synchronous memory port.
// Define SPELL_MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the host wins ties.
module spell_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_host
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                gh_q, gh_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                h_ack_q, h_ack_d;
    logic                c_ack_q, c_ack_d;
    logic [DATA_W-1:0]   h_rdata_q, h_rdata_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;

    logic h_elig, c_elig, tie_host, pick_host;

    // A requester seeing its own ack this cycle is finishing, not asking again.
    assign h_elig    = h_req & ~h_ack_q;
    assign c_elig    = c_req & ~c_ack_q;
    assign pick_host = h_elig & (~c_elig | tie_host);

`ifdef SPELL_MEM_ARB_ROUND_ROBIN_EN
    logic last_host_q, last_host_d;

    assign tie_host = ~last_host_q;

    always_comb begin
        last_host_d = last_host_q;
        if (state_q == IDLE && (h_elig || c_elig)) begin
            last_host_d = pick_host;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_host_q <= 1'b1;
        end else begin
            last_host_q <= last_host_d;
        end
    end
`else
    assign tie_host = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        gh_d      = gh_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        h_ack_d   = 1'b0;
        c_ack_d   = 1'b0;
        h_rdata_d = h_rdata_q;
        c_rdata_d = c_rdata_q;
        case (state_q)
            IDLE: begin
                if (h_elig || c_elig) begin
                    gh_d    = pick_host;
                    we_d    = pick_host ? h_we    : c_we;
                    addr_d  = pick_host ? h_addr  : c_addr;
                    wdata_d = pick_host ? h_wdata : c_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = CAPTURE;
            CAPTURE: begin
                if (gh_q) begin
                    h_rdata_d = mem_rdata;
                    h_ack_d   = 1'b1;
                end else begin
                    c_rdata_d = mem_rdata;
                    c_ack_d   = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gh_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            h_ack_q   <= 1'b0;
            c_ack_q   <= 1'b0;
            h_rdata_q <= '0;
            c_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gh_q      <= gh_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            h_ack_q   <= h_ack_d;
            c_ack_q   <= c_ack_d;
            h_rdata_q <= h_rdata_d;
            c_rdata_q <= c_rdata_d;
        end
    end

    assign mem_en     = (state_q == ACCESS);
    assign mem_we     = mem_en & we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != IDLE);
    assign grant_host = gh_q;
    assign h_ack      = h_ack_q;
    assign c_ack      = c_ack_q;
    assign h_rdata    = h_rdata_q;
    assign c_rdata    = c_rdata_q;

endmodule
